// File: rtl/layer1_result_collector.sv
// Layer-1 result collector: sums the per-channel partial sums over the kernel
// taps, adds bias, saturates and applies ReLU, then streams the eight
// activations one channel per beat.
module layer1_result_collector #(
  parameter int unsigned TAPS  = 9,
  parameter int unsigned PIX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_ch1,
  input  logic [15:0]      in_ch2,
  input  logic [15:0]      in_ch3,
  input  logic [15:0]      in_ch4,
  input  logic [15:0]      in_ch5,
  input  logic [15:0]      in_ch6,
  input  logic [15:0]      in_ch7,
  input  logic [15:0]      in_ch8,
  input  logic [127:0]     bias_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [2:0]       out_ch,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_last
);

  localparam int unsigned TapW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [TapW-1:0] LastTap = TapW'(TAPS - 1);

  typedef enum logic {StAccum, StDrain} state_e;

  state_e           r_state, w_state_d;
  logic [TapW-1:0]  r_tap, w_tap_d;
  logic [2:0]       r_ch, w_ch_d;
  logic [PIX_W-1:0] r_pix, w_pix_d;
  logic [19:0]      r_acc [8];
  logic [19:0]      w_acc_d [8];
  logic [15:0]      r_res [8];
  logic [15:0]      w_res_d [8];
  logic [15:0]      w_in [8];
  logic [20:0]      w_sum [8];
  logic             w_accept;
  logic             w_final;
  logic             w_out_hs;

  assign w_in[0] = in_ch1;
  assign w_in[1] = in_ch2;
  assign w_in[2] = in_ch3;
  assign w_in[3] = in_ch4;
  assign w_in[4] = in_ch5;
  assign w_in[5] = in_ch6;
  assign w_in[6] = in_ch7;
  assign w_in[7] = in_ch8;

  assign w_accept = (r_state == StAccum) && in_valid;
  assign w_final  = w_accept && (r_tap == LastTap);
  assign w_out_hs = (r_state == StDrain) && out_ready;

  // Clamp a 21-bit signed sum to 0..32767 (saturate to int16, then ReLU).
  function automatic logic [15:0] sat_relu(input logic [20:0] s);
    if (s[20]) begin
      return 16'd0;
    end else if (|s[19:15]) begin
      return 16'd32767;
    end else begin
      return {1'b0, s[14:0]};
    end
  endfunction

  // Final-tap sums: accumulator + current partial sum + bias, all sign-extended.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_sum[k] = {r_acc[k][19], r_acc[k]}
               + {{5{w_in[k][15]}}, w_in[k]}
               + {{5{bias_in[16*k+15]}}, bias_in[16*k +: 16]};
    end
  end

  // Next-state logic for the FSM, accumulators, results and output counters.
  always_comb begin
    w_state_d = r_state;
    w_tap_d   = r_tap;
    w_ch_d    = r_ch;
    w_pix_d   = r_pix;
    for (int k = 0; k < 8; k++) begin
      w_acc_d[k] = r_acc[k];
      w_res_d[k] = r_res[k];
    end
    unique case (r_state)
      StAccum: begin
        if (w_final) begin
          for (int k = 0; k < 8; k++) begin
            w_res_d[k] = sat_relu(w_sum[k]);
            w_acc_d[k] = '0;
          end
          w_tap_d   = '0;
          w_state_d = StDrain;
        end else if (w_accept) begin
          for (int k = 0; k < 8; k++) begin
            w_acc_d[k] = r_acc[k] + {{4{w_in[k][15]}}, w_in[k]};
          end
          w_tap_d = r_tap + 1'b1;
        end
      end
      StDrain: begin
        if (w_out_hs) begin
          w_ch_d = r_ch + 3'd1;
          if (r_ch == 3'd7) begin
            w_pix_d   = r_pix + 1'b1;
            w_state_d = StAccum;
          end
        end
      end
      default: w_state_d = StAccum;
    endcase
  end

  // State registers; reset discards partial sums and pending results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StAccum;
      r_tap   <= '0;
      r_ch    <= '0;
      r_pix   <= '0;
      for (int k = 0; k < 8; k++) begin
        r_acc[k] <= '0;
        r_res[k] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      r_tap   <= w_tap_d;
      r_ch    <= w_ch_d;
      r_pix   <= w_pix_d;
      for (int k = 0; k < 8; k++) begin
        r_acc[k] <= w_acc_d[k];
        r_res[k] <= w_res_d[k];
      end
    end
  end

  // Handshake flags depend on state only; data is zeroed outside DRAIN.
  always_comb begin
    in_ready  = (r_state == StAccum);
    out_valid = (r_state == StDrain);
    out_ch    = r_ch;
    out_pix   = r_pix;
    out_data  = out_valid ? r_res[r_ch] : 16'd0;
    out_last  = out_valid && (r_ch == 3'd7);
  end

endmodule

// File: tb/tb_layer1_result_collector.sv
// Self-checking bench for layer1_result_collector: directed cases plus a long
// randomized run with input gaps and output backpressure against a sum model.
module tb_layer1_result_collector;

  localparam int unsigned TAPS  = 9;
  localparam int unsigned PIX_W = 10;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_ch [8];
  logic [127:0]     bias_in;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [2:0]       out_ch;
  logic [PIX_W-1:0] out_pix;
  logic             out_last;

  layer1_result_collector #(.TAPS(TAPS), .PIX_W(PIX_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch1    (in_ch[0]),
    .in_ch2    (in_ch[1]),
    .in_ch3    (in_ch[2]),
    .in_ch4    (in_ch[3]),
    .in_ch5    (in_ch[4]),
    .in_ch6    (in_ch[5]),
    .in_ch7    (in_ch[6]),
    .in_ch8    (in_ch[7]),
    .bias_in   (bias_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_pix   (out_pix),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      data;
    logic [2:0]       ch;
    logic [PIX_W-1:0] pix;
    logic             last;
  } exp_t;

  exp_t             exp_q[$];
  logic [15:0]      g_tap [TAPS][8];
  logic [127:0]     g_bias;
  logic [PIX_W-1:0] m_pix;
  int               n_checks;
  int               n_errors;
  int               bp_mode;  // 0: ready high, 1: random, 2: driven by main

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: plain integer sum over taps plus bias, clamped to 0..32767.
  function automatic logic [15:0] ref_act(input int k);
    int s;
    logic [15:0] b;
    s = 0;
    for (int t = 0; t < TAPS; t++) s += int'($signed(g_tap[t][k]));
    b = g_bias[16*k +: 16];
    s += int'($signed(b));
    if (s < 0) return 16'd0;
    if (s > 32767) return 16'd32767;
    return 16'(s);
  endfunction

  task automatic push_expect();
    for (int k = 0; k < 8; k++) exp_q.push_back('{ref_act(k), 3'(k), m_pix, (k == 7)});
    m_pix = m_pix + 1'b1;
  endtask

  // Drive n taps from g_tap; called and returns just after a rising edge.
  task automatic drive_taps(input int n, input int gap_pct);
    bit acc;
    int guard;
    for (int t = 0; t < n; t++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        bias_in  = rand128();
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) in_ch[k] = g_tap[t][k];
      bias_in = (t == TAPS - 1) ? g_bias : rand128();
      guard = 0;
      forever begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        if (acc) break;
        guard++;
        if (guard > 500) begin
          check("in_hs_timeout", 0, 1);
          break;
        end
      end
      in_valid = 1'b0;
      bias_in  = rand128();
      if (t == TAPS - 1) begin
        check("lat_out_valid", out_valid, 1);
        check("lat_in_ready", in_ready, 0);
      end
    end
  endtask

  task automatic send_pixel(input int gap_pct);
    push_expect();
    drive_taps(TAPS, gap_pct);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 || !in_ready) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 3000) begin
        check("idle_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_pix", out_pix, 0);
    check("rst_out_last", out_last, 0);
    exp_q.delete();
    m_pix    = '0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fill_const(input logic [15:0] v, input logic [15:0] b);
    for (int t = 0; t < TAPS; t++)
      for (int k = 0; k < 8; k++) g_tap[t][k] = v;
    g_bias = {8{b}};
  endtask

  task automatic fill_random();
    bit wide;
    wide = ($urandom_range(0, 3) == 0);
    for (int t = 0; t < TAPS; t++)
      for (int k = 0; k < 8; k++)
        g_tap[t][k] = wide ? 16'($urandom()) : 16'($urandom_range(0, 400) - 200);
    for (int k = 0; k < 8; k++)
      g_bias[16*k +: 16] = wide ? 16'($urandom()) : 16'($urandom_range(0, 600) - 300);
  endtask

  // Output ready generator for the automatic modes.
  always @(posedge clk) begin
    #1;
    if (bp_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    else if (bp_mode == 0) out_ready = 1'b1;
  end

  // Output monitor: ordered scoreboard, hold stability, ready after last beat.
  logic             h_valid;
  logic [15:0]      h_data;
  logic [2:0]       h_ch;
  logic [PIX_W-1:0] h_pix;
  logic             h_last;
  logic             last_seen;
  exp_t             e;

  always @(negedge clk) begin
    if (rst) begin
      h_valid   = 1'b0;
      last_seen = 1'b0;
    end else begin
      check("ready_vs_valid", in_ready, !out_valid);
      if (last_seen) begin
        check("ready_after_last", in_ready, 1);
        last_seen = 1'b0;
      end
      if (h_valid) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, h_data);
        check("hold_ch", out_ch, h_ch);
        check("hold_pix", out_pix, h_pix);
        check("hold_last", out_last, h_last);
        h_valid = 1'b0;
      end
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_ch", out_ch, e.ch);
            check("out_pix", out_pix, e.pix);
            check("out_last", out_last, e.last);
            last_seen = out_last;
          end
        end else begin
          h_valid = 1'b1;
          h_data  = out_data;
          h_ch    = out_ch;
          h_pix   = out_pix;
          h_last  = out_last;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    n_checks  = 0;
    n_errors  = 0;
    bp_mode   = 0;
    h_valid   = 1'b0;
    last_seen = 1'b0;
    m_pix     = '0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    bias_in   = '0;
    for (int k = 0; k < 8; k++) in_ch[k] = '0;
    #2;
    do_reset();

    // Basic accumulation: nine ones per channel, no bias.
    fill_const(16'd1, 16'd0);
    send_pixel(0);
    wait_idle();

    // Bias and ReLU.
    fill_random();
    for (int t = 0; t < TAPS; t++) begin
      g_tap[t][0] = -16'sd5;
      g_tap[t][1] = -16'sd5;
      g_tap[t][2] = 16'd3;
    end
    g_bias[15:0]  = 16'd40;
    g_bias[31:16] = 16'd0;
    g_bias[47:32] = 16'd2;
    send_pixel(0);
    wait_idle();

    // Saturation at both ends.
    fill_const(16'd0, 16'd0);
    for (int t = 0; t < TAPS; t++) begin
      g_tap[t][0] = 16'd32767;
      g_tap[t][1] = 16'h8000;
    end
    g_bias[15:0] = 16'd32767;
    send_pixel(0);
    wait_idle();

    // Backpressure at channel 3 with the next beat already offered.
    bp_mode   = 2;
    out_ready = 1'b1;
    fill_random();
    send_pixel(0);
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) in_ch[k] = 16'($urandom());
    guard = 0;
    while (out_ch != 3'd3 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_ch", out_ch, 3);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    guard = 0;
    forever begin
      @(negedge clk);
      if ((out_valid && out_last) || guard > 50) break;
      guard++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_ready_back", in_ready, 1);
    wait_idle();
    bp_mode = 0;

    // Reset after four taps, then after two drain beats.
    fill_random();
    drive_taps(4, 0);
    do_reset();
    fill_random();
    send_pixel(0);
    guard = 0;
    while (out_ch != 3'd2 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    do_reset();
    fill_const(16'd2, 16'd0);
    send_pixel(0);
    wait_idle();

    // Long randomized run across the pixel-index wrap.
    bp_mode = 1;
    for (int p = 0; p < (1 << PIX_W) + 1; p++) begin
      fill_random();
      send_pixel(25);
    end
    wait_idle();
    bp_mode = 0;
    @(posedge clk); #1;
    check("final_pix", out_pix, 10'(m_pix));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
